cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Miss-handling sequencer for one 128-block x 8-word cache data array plus its tag array.
- On a miss it issues 8 pipelined word reads to main memory. It steers each returned word into the data array using a one-hot word enable and write strobe. On the last word it pulses the tag-array write.
- Sits between cache hit/miss logic, the data/tag arrays, and the multi-cycle memory module. One controller instance per cache.

Parameters:
- ADDR_W, 16, byte-address width of miss and memory addresses.
- WORDS, 8, words per cache block; power of two; word is 16 bits, block is 16 bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; state cleared immediately on assertion.
- miss_detected  input  1  level; high while the cache reports a miss.
- miss_address  input  ADDR_W  byte address of the missing access; sampled in IDLE when miss_detected=1.
- memory_data_valid  input  1  memory returns one word this cycle.
- memory_data  input  16  returned word.
- fsm_busy  output  1  high from the cycle after a miss is accepted until the fill completes; stalls the pipeline.
- mem_read  output  1  read request to memory this cycle.
- memory_address  output  ADDR_W  address of the current read request.
- write_data_array  output  1  data-array write strobe.
- word_enable  output  WORDS  one-hot word select for the data-array write.
- data_to_array  output  16  data for the data-array write.
- write_tag_array  output  1  one-cycle tag/valid write pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE; issue_cnt=0, recv_cnt=0, base address=0. Outputs: fsm_busy=0, mem_read=0, memory_address=0, write_data_array=0, word_enable=0, write_tag_array=0, data_to_array=0.
- State IDLE:
  - If miss_detected=1: latch base = {miss_address[ADDR_W-1:4], 4'b0}, clear both counters, go to FILL.
  - Otherwise stay in IDLE. memory_data_valid is ignored.
- State FILL:
  - fsm_busy=1.
  - Issue side: while issue_cnt < WORDS, mem_read=1 and memory_address = base + 2*issue_cnt; issue_cnt increments every cycle. Once issue_cnt=WORDS, mem_read=0 and memory_address holds its last value.
  - Receive side: when memory_data_valid=1, write_data_array=1, word_enable = one-hot(recv_cnt), data_to_array = memory_data, and recv_cnt increments. When memory_data_valid=0, write_data_array=0 and word_enable=0.
  - The issue and receive sides are independent, so an issue and a receive in the same cycle are both serviced.
  - The memory returns words in request order, and no response arrives before its request. The controller does not check memory latency.
  - When the word received has recv_cnt=WORDS-1: write_tag_array=1 in the same cycle, then the next state is IDLE. fsm_busy=0 from the next cycle.
- All outputs are combinational from state, counters and inputs. No data is buffered; memory_data passes straight through to data_to_array.
- Boundaries:
  - miss_detected is ignored while in FILL. After completion, if miss_detected is still high in IDLE, a new fill starts one cycle later. The cache must have re-evaluated the miss, which is now a hit.
  - memory_data_valid in IDLE, or after the 8th word, produces no write.
  - Counters are sized log2(WORDS)+1 bits; no wrap occurs within a fill.
  - Reset asserted mid-FILL aborts the fill: no tag write, array contents stay partial. A stale memory response after reset is ignored because the state is IDLE.
- Minimum fill time = memory latency L + WORDS cycles after the miss is accepted.

Test Plan:
- Reset: hold rst=0 with random inputs, then release -> all outputs 0 and state IDLE. Assert rst=0 asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Basic fill, L=4: miss_address=0x1236 -> mem_read high for 8 cycles with addresses 0x1230, 0x1232, ... 0x123E. Words 0xA000..0xA007 written with word_enable 0x01..0x80. write_tag_array pulses with the 8th word; fsm_busy spans 12 cycles.
- Gapped returns: memory_data_valid toggled 1,0,1,0 -> writes occur only on valid cycles, word_enable advances only on valid. Tag pulse occurs exactly on the 8th valid.
- Spurious inputs: memory_data_valid=1 in IDLE, and a new miss_detected with miss_address=0x4000 during FILL -> no writes, base stays 0x1230.
- Back-to-back: miss_detected held high through completion -> IDLE for one cycle, then a new fill from the re-latched address.
- Reset mid-fill: rst=0 after 3 words received -> write_tag_array never pulses. A new miss at 0x2000 then fills correctly from word 0.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill sequencer: issues WORDS pipelined word reads for the missing
// block, steers returned words into the data array and writes the tag on the last.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [WORDS-1:0]  word_enable,
    output logic [15:0]       data_to_array,
    output logic              write_tag_array
);

    localparam int CW  = $clog2(WORDS) + 1;
    localparam int OFF = $clog2(WORDS) + 1;   // byte offset bits within a block of 16-bit words

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     issue_cnt, recv_cnt;
    logic [ADDR_W-1:0] base;
    logic              issue_active, recv_fire, last_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                base      <= {miss_address[ADDR_W-1:OFF], {OFF{1'b0}}};
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
        end else begin
            if (issue_active) issue_cnt <= issue_cnt + 1'b1;
            if (recv_fire)    recv_cnt  <= recv_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss_detected) next_state = FILL;
            FILL:    if (last_word)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Issue and receive sides run independently; both may fire in one cycle.
    always_comb begin
        issue_active     = 1'b0;
        recv_fire        = 1'b0;
        last_word        = 1'b0;
        fsm_busy         = 1'b0;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_enable      = '0;
        data_to_array    = '0;
        write_tag_array  = 1'b0;
        if (state == FILL) begin
            fsm_busy     = 1'b1;
            issue_active = (issue_cnt < CW'(WORDS));
            recv_fire    = memory_data_valid && (recv_cnt < CW'(WORDS));
            last_word    = recv_fire && (recv_cnt == CW'(WORDS - 1));
            mem_read     = issue_active;
            if (issue_active)
                memory_address = base + (ADDR_W'(issue_cnt) << 1);
            else
                memory_address = base + ADDR_W'(2 * (WORDS - 1));
            if (recv_fire) begin
                write_data_array = 1'b1;
                word_enable      = WORDS'(1) << recv_cnt;
                data_to_array    = memory_data;
            end
            write_tag_array = last_word;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: a memory model drives returned words,
// expected array writes are queued as they are driven and popped on DUT writes.
module tb_cache_fill_ctrl;

    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [7:0]  word_enable;
    logic [15:0] data_to_array;
    logic        write_tag_array;
    logic [43:0] all_outs;

    int n_tests = 0;
    int n_fail  = 0;
    logic [24:0] sb[$];   // {tag, word_enable, data}

    cache_fill_ctrl #(.ADDR_W(16), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_read(mem_read), .memory_address(memory_address),
        .write_data_array(write_data_array), .word_enable(word_enable),
        .data_to_array(data_to_array), .write_tag_array(write_tag_array)
    );

    assign all_outs = {fsm_busy, mem_read, memory_address, write_data_array,
                       word_enable, data_to_array, write_tag_array};

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            miss_detected     = 1'($urandom);
            miss_address      = 16'($urandom);
            memory_data_valid = 1'($urandom);
            memory_data       = 16'($urandom);
            #1 n_tests++;
            if (all_outs !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h, expected 0", all_outs);
            end
        end
        @(negedge clk);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        rst               = 1'b1;
        #1 n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got %h, expected 0", all_outs);
        end
        @(negedge clk);
        memory_data_valid = 1'b0;
        #1 n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h, expected 0", all_outs);
        end
    endtask

    // Drives one complete miss: acceptance cycle then the fill, with memory
    // responses lat cycles after each request (optionally only on even cycles).
    task automatic run_fill(input logic [15:0] addr, input int lat, input bit gapped,
                            input bit spurious, input bit hold, input int abort_after,
                            input logic [15:0] seed, input int exp_busy);
        logic [15:0] base;
        logic [15:0] exp_addr;
        logic [24:0] e;
        int issued;
        int recvd;
        int cyc;
        bit v;
        base   = {addr[15:4], 4'h0};
        issued = 0;
        recvd  = 0;
        @(negedge clk);
        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        #1 n_tests++;
        if (fsm_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_busy: got %b, expected 0", fsm_busy);
        end
        for (cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            v = (recvd < WORDS) && (cyc >= recvd + lat) && (!gapped || (cyc % 2 == 0));
            miss_detected = hold || (spurious && !(v && recvd == WORDS - 1));
            if (spurious) miss_address = 16'h4000;
            memory_data_valid = v;
            memory_data       = v ? seed + 16'(recvd) : 16'($urandom);
            if (v) sb.push_back({(recvd == WORDS - 1), 8'(1 << recvd), seed + 16'(recvd)});
            #1 n_tests++;
            if (fsm_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_busy: cycle %0d got %b, expected 1", cyc, fsm_busy);
            end
            exp_addr = base + 16'(2 * ((issued < WORDS) ? issued : WORDS - 1));
            n_tests++;
            if ({mem_read, memory_address} !== {(issued < WORDS), exp_addr}) begin
                n_fail++;
                $display("FAIL issue: cycle %0d got rd=%b addr=%h, expected rd=%b addr=%h",
                         cyc, mem_read, memory_address, (issued < WORDS), exp_addr);
            end
            n_tests++;
            if (write_data_array) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: cycle %0d got we=%h, expected no write", cyc, word_enable);
                end else begin
                    e = sb.pop_front();
                    if ({write_tag_array, word_enable, data_to_array} !== e) begin
                        n_fail++;
                        $display("FAIL write: cycle %0d got %h, expected %h", cyc,
                                 {write_tag_array, word_enable, data_to_array}, e);
                    end
                end
            end else if (v || {write_tag_array, word_enable} !== '0) begin
                n_fail++;
                $display("FAIL no_write: cycle %0d got tag=%b we=%h, expected write=%b",
                         cyc, write_tag_array, word_enable, v);
            end
            if (issued < WORDS) issued++;
            if (v) recvd++;
            if (abort_after > 0 && recvd == abort_after) begin
                #3 rst = 1'b0;
                #1 n_tests++;
                if (all_outs !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: got %h, expected 0", all_outs);
                end
                @(negedge clk);
                miss_detected     = 1'b0;
                memory_data_valid = 1'b1;
                memory_data       = 16'hDEAD;
                rst               = 1'b1;
                #1 n_tests++;
                if (all_outs !== '0) begin
                    n_fail++;
                    $display("FAIL stale_response: got %h, expected 0", all_outs);
                end
                @(negedge clk);
                memory_data_valid = 1'b0;
                #1 n_tests++;
                if (all_outs !== '0) begin
                    n_fail++;
                    $display("FAIL after_abort: got %h, expected 0", all_outs);
                end
                sb.delete();
                return;
            end
            if (recvd == WORDS) break;
        end
        n_tests++;
        if (recvd != WORDS) begin
            n_fail++;
            $display("FAIL fill_timeout: got %0d words, expected %0d", recvd, WORDS);
        end
        if (exp_busy > 0) begin
            n_tests++;
            if (cyc + 1 != exp_busy) begin
                n_fail++;
                $display("FAIL busy_span: got %0d cycles, expected %0d", cyc + 1, exp_busy);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_basic();
        run_fill(16'h1236, 4, 1'b0, 1'b0, 1'b0, 0, 16'hA000, 12);
    endtask

    task automatic test_gapped();
        run_fill(16'h0A4E, 4, 1'b1, 1'b0, 1'b0, 0, 16'h5100, 0);
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            miss_detected     = 1'b0;
            memory_data_valid = 1'b1;
            memory_data       = 16'h7777;
            #1 n_tests++;
            if ({write_data_array, word_enable, write_tag_array, fsm_busy} !== '0) begin
                n_fail++;
                $display("FAIL idle_valid: got we=%b en=%h tag=%b busy=%b, expected 0",
                         write_data_array, word_enable, write_tag_array, fsm_busy);
            end
        end
        run_fill(16'h1236, 3, 1'b0, 1'b1, 1'b0, 0, 16'hB000, 11);
        @(negedge clk);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        #1 n_tests++;
        if ({fsm_busy, mem_read} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_spurious_idle: got busy=%b rd=%b, expected 0 0", fsm_busy, mem_read);
        end
    endtask

    task automatic test_back_to_back();
        run_fill(16'h3458, 4, 1'b0, 1'b0, 1'b1, 0, 16'hD000, 12);
        run_fill(16'h7A1C, 2, 1'b0, 1'b0, 1'b0, 0, 16'hE000, 10);
    endtask

    task automatic test_reset_mid_fill();
        run_fill(16'h1236, 4, 1'b0, 1'b0, 1'b0, 3, 16'hF000, 0);
        run_fill(16'h2000, 2, 1'b0, 1'b0, 1'b0, 0, 16'hC000, 10);
    endtask

    initial begin
        rst               = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        test_reset();
        test_basic();
        test_gapped();
        test_spurious();
        test_back_to_back();
        test_reset_mid_fill();
        @(negedge clk);
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
